// File: rtl/mod_n_ctr.sv
// Free-running modulo-N up-counter with a registered terminal-count flag.
// Define MOD_N_CTR_ASSERT_EN to compile in simulation-only consistency checks.
module mod_n_ctr #(
  parameter int N     = 10,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  output logic [WIDTH-1:0] out,
  output logic             tc
);

  // Reject moduli that cannot be represented or that have no second state.
  if (N < 2 || N > (1 << WIDTH)) begin : g_bad_params
    $error("mod_n_ctr: illegal N=%0d for WIDTH=%0d (need 2 <= N <= 2**WIDTH)", N, WIDTH);
  end

  localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;

  // The ">= LAST" compare also folds any unreachable state (count >= N) back to 0.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    count_d = '0;
    if (count_q < LAST) begin
      count_d = count_q + WIDTH'(1);
    end
    tc_d = (count_d == LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign out = count_q;
  assign tc  = tc_q;

`ifdef MOD_N_CTR_ASSERT_EN
  always @(posedge clk) begin
    if (rstn) begin
      if (int'(count_q) >= N) begin
        $error("mod_n_ctr: count %0d out of range for N=%0d", count_q, N);
      end
      if (tc_q != (count_q == LAST)) begin
        $error("mod_n_ctr: tc=%0b inconsistent with count %0d", tc_q, count_q);
      end
    end else if (count_q != '0) begin
      $error("mod_n_ctr: count %0d nonzero while in reset", count_q);
    end
  end
`endif

endmodule

// File: tb/tb_mod_n_ctr.sv
// Scoreboard bench for mod_n_ctr: three instances (N=10/W=4, N=16/W=4, N=3/W=2)
// share clk and rstn; a reference model pushes expected counts before each edge.
module tb_mod_n_ctr;

  typedef struct {
    int unsigned dut;
    logic [3:0]  out;
    logic        tc;
  } exp_t;

  logic       clk;
  logic       rstn;
  logic [3:0] out10;
  logic [3:0] out16;
  logic [1:0] out3;
  logic       tc10;
  logic       tc16;
  logic       tc3;

  logic [3:0]  obs_out [3];
  logic        obs_tc  [3];
  int unsigned m       [3];
  exp_t        sb[$];
  int          compared   = 0;
  int          mismatched = 0;

  assign obs_out[0] = out10;
  assign obs_out[1] = out16;
  assign obs_out[2] = {2'b00, out3};
  assign obs_tc[0]  = tc10;
  assign obs_tc[1]  = tc16;
  assign obs_tc[2]  = tc3;

  mod_n_ctr #(.N(10), .WIDTH(4)) u_n10 (.clk(clk), .rstn(rstn), .out(out10), .tc(tc10));
  mod_n_ctr #(.N(16), .WIDTH(4)) u_n16 (.clk(clk), .rstn(rstn), .out(out16), .tc(tc16));
  mod_n_ctr #(.N(3),  .WIDTH(2)) u_n3  (.clk(clk), .rstn(rstn), .out(out3),  .tc(tc3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int unsigned n_of(input int unsigned i);
    case (i)
      0:       return 10;
      1:       return 16;
      default: return 3;
    endcase
  endfunction

  // Push the expected post-edge value of every instance, then take the edge.
  task automatic advance();
    for (int i = 0; i < 3; i++) begin
      int unsigned n  = n_of(i);
      int unsigned nx = (m[i] >= n - 1) ? 0 : m[i] + 1;
      m[i] = nx;
      sb.push_back('{dut: i, out: 4'(nx), tc: (nx == n - 1)});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m[i] = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    exp_t e;
    rstn = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        compared++;
        if (obs_out[i] !== 4'h0 || obs_tc[i] !== 1'b0) begin
          mismatched++;
          $display("FAIL reset_hold dut%0d k%0d: out=%h tc=%b, expected out=0 tc=0",
                   i, k, obs_out[i], obs_tc[i]);
        end
      end
      @(posedge clk);
      #1;
    end
    // Release just after the second reset edge.
    #1 rstn = 1'b1;
    e = '{dut: 0, out: 4'h0, tc: 1'b0};
    compared++;
    if (out10 !== e.out) begin
      mismatched++;
      $display("FAIL release_idle: out=%h, expected %h", out10, e.out);
    end
  endtask

  task automatic test_count();
    exp_t e;
    int   tc_hits = 0;
    for (int k = 1; k <= 20; k++) begin
      advance();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        compared++;
        if (obs_out[e.dut] !== e.out || obs_tc[e.dut] !== e.tc) begin
          mismatched++;
          $display("FAIL count dut%0d edge%0d: out=%h tc=%b, expected out=%h tc=%b",
                   e.dut, k, obs_out[e.dut], obs_tc[e.dut], e.out, e.tc);
        end
      end
      if (tc10 === 1'b1) tc_hits++;
    end
    compared++;
    if (tc_hits != 2 || out10 !== 4'h0) begin
      mismatched++;
      $display("FAIL count_period: tc pulses=%0d out=%h, expected 2 pulses and out=0", tc_hits, out10);
    end
  endtask

  task automatic async_reset_check(input string name);
    exp_t e;
    @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (obs_out[i] !== 4'h0 || obs_tc[i] !== 1'b0) begin
        mismatched++;
        $display("FAIL %s_immediate dut%0d: out=%h tc=%b, expected out=0 tc=0",
                 name, i, obs_out[i], obs_tc[i]);
      end
    end
    @(posedge clk);
    #1;
    compared++;
    if (out10 !== 4'h0 || tc10 !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_held: out=%h tc=%b, expected out=0 tc=0", name, out10, tc10);
    end
    @(negedge clk);
    rstn = 1'b1;
    advance();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      compared++;
      if (obs_out[e.dut] !== e.out || obs_tc[e.dut] !== e.tc) begin
        mismatched++;
        $display("FAIL %s_resume dut%0d: out=%h tc=%b, expected out=%h tc=%b",
                 name, e.dut, obs_out[e.dut], obs_tc[e.dut], e.out, e.tc);
      end
    end
  endtask

  task automatic run_until(input int unsigned target, input string name);
    exp_t e;
    for (int k = 0; k < 20 && m[0] != target; k++) begin
      advance();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        compared++;
        if (obs_out[e.dut] !== e.out || obs_tc[e.dut] !== e.tc) begin
          mismatched++;
          $display("FAIL %s_run dut%0d: out=%h tc=%b, expected out=%h tc=%b",
                   name, e.dut, obs_out[e.dut], obs_tc[e.dut], e.out, e.tc);
        end
      end
    end
  endtask

  task automatic test_async_mid();
    run_until(6, "async_mid");
    compared++;
    if (out10 !== 4'h6) begin
      mismatched++;
      $display("FAIL async_mid_pre: out=%h, expected 6", out10);
    end
    async_reset_check("async_mid");
  endtask

  task automatic test_reset_at_tc();
    run_until(9, "reset_tc");
    compared++;
    if (out10 !== 4'h9 || tc10 !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_tc_pre: out=%h tc=%b, expected out=9 tc=1", out10, tc10);
    end
    async_reset_check("reset_tc");
  endtask

  task automatic test_pow2_and_small();
    exp_t e;
    logic saw_f_tc = 1'b0;
    for (int k = 0; k < 36; k++) begin
      advance();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        compared++;
        if (obs_out[e.dut] !== e.out || obs_tc[e.dut] !== e.tc) begin
          mismatched++;
          $display("FAIL modulus dut%0d step%0d: out=%h tc=%b, expected out=%h tc=%b",
                   e.dut, k, obs_out[e.dut], obs_tc[e.dut], e.out, e.tc);
        end
      end
      if (out16 === 4'hF && tc16 === 1'b1) saw_f_tc = 1'b1;
      compared++;
      if (out3 === 2'd3) begin
        mismatched++;
        $display("FAIL mod3_range step%0d: out=%0d, expected < 3", k, out3);
      end
    end
    compared++;
    if (saw_f_tc !== 1'b1) begin
      mismatched++;
      $display("FAIL mod16_tc: saw_f_tc=%b, expected 1", saw_f_tc);
    end
  endtask

  task automatic test_illegal_recovery();
    exp_t e;
    @(negedge clk);
    force u_n10.count_q = 4'hC;
    #1 release u_n10.count_q;
    #1;
    compared++;
    if (out10 !== 4'hC) begin
      mismatched++;
      $display("FAIL illegal_inject: out=%h, expected c", out10);
    end
    m[0] = 12;
    for (int k = 0; k < 2; k++) begin
      advance();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        compared++;
        if (obs_out[e.dut] !== e.out || obs_tc[e.dut] !== e.tc) begin
          mismatched++;
          $display("FAIL illegal_recover dut%0d step%0d: out=%h tc=%b, expected out=%h tc=%b",
                   e.dut, k, obs_out[e.dut], obs_tc[e.dut], e.out, e.tc);
        end
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    test_reset();
    test_count();
    test_async_mid();
    test_reset_at_tc();
    test_pow2_and_small();
    test_illegal_recovery();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
